// File: rtl/ws2812_pkg.sv
// ---------------------------------------------------------------------------
// ws2812_pkg
//   Shared types and helpers for the WS2812 strip fill path.
//   GRB_W       : width of a GRB colour word
//   CMD_IDX_W   : width of the index/count fields carried in fill_cmd_t
//   fill_cmd_t  : range-fill command {start, count, color}
//   state_t     : fill sequencer states
//   strip_count : strip memory depth for a chain of led_count LEDs (LED0 is
//                 the status LED and not part of the strip memory)
// ---------------------------------------------------------------------------
package ws2812_pkg;

  localparam int unsigned GRB_W     = 24;
  localparam int unsigned CMD_IDX_W = 16;

  typedef struct packed {
    logic [CMD_IDX_W-1:0] start;
    logic [CMD_IDX_W-1:0] count;
    logic [GRB_W-1:0]     color;
  } fill_cmd_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  function automatic int unsigned strip_count(input int unsigned led_count);
    return led_count - 1;
  endfunction

endpackage

// File: rtl/ws2812_rr_arb2.sv
// ---------------------------------------------------------------------------
// ws2812_rr_arb2
//   Two-requester round-robin arbiter with a registered last-grant flag.
//   clk_g   in   clock
//   rst_n   in   asynchronous active-low reset
//   req     in   [1:0] requests (bit0 = host, bit1 = fx), already qualified
//   accept  in   grant taken this cycle; updates the last-grant flag
//   gnt     out  [1:0] one-hot grant (combinational), 0 when no request
//   last    out  requester served last (0 = host, 1 = fx); resets to 1 so
//                the host wins the first tie
// ---------------------------------------------------------------------------
module ws2812_rr_arb2 (
  input  logic       clk_g,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       last
);

  logic r_last;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (accept) begin
      r_last <= gnt[1];
    end
  end

  assign last = r_last;

endmodule

// File: rtl/ws2812_strip_fill_arbiter.sv
// ---------------------------------------------------------------------------
// ws2812_strip_fill_arbiter
//   Shares the WS2812 driver strip write port between the host command path
//   and the effect engine. Commands are range fills; they are arbitrated
//   round-robin per command, clipped to the strip memory, then sequenced as
//   one strip write per clock.
//   clk_g / rst_n               clock, asynchronous active-low reset
//   host_valid/ready/start/count/color   host command handshake + fields
//   fx_valid/ready/start/count/color     effect-engine handshake + fields
//   strip_write/index/color_grb          driver write port (registered)
//   busy      high while filling
//   grant_fx  owner of current/last command (0 = host, 1 = fx)
//   cmd_done  pulse: accepted command finished (with its last write)
//   err_clip  pulse: command range truncated or fully out of range
// ---------------------------------------------------------------------------
module ws2812_strip_fill_arbiter
  import ws2812_pkg::*;
#(
  parameter int unsigned LED_COUNT = 150,
  // fill_cmd_t carries CMD_IDX_W-wide fields; keep IDX_W equal to it
  parameter int unsigned IDX_W     = CMD_IDX_W
) (
  input  logic             clk_g,
  input  logic             rst_n,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic [IDX_W-1:0] host_start,
  input  logic [IDX_W-1:0] host_count,
  input  logic [GRB_W-1:0] host_color,
  input  logic             fx_valid,
  output logic             fx_ready,
  input  logic [IDX_W-1:0] fx_start,
  input  logic [IDX_W-1:0] fx_count,
  input  logic [GRB_W-1:0] fx_color,
  output logic             strip_write,
  output logic [IDX_W-1:0] strip_index,
  output logic [GRB_W-1:0] strip_color_grb,
  output logic             busy,
  output logic             grant_fx,
  output logic             cmd_done,
  output logic             err_clip
);

  localparam int unsigned   STRIP_COUNT = strip_count(LED_COUNT);
  localparam logic [IDX_W:0] LP_SC      = STRIP_COUNT[IDX_W:0];
  localparam logic [IDX_W:0] LP_ONE_X   = 1;
  localparam logic [IDX_W-1:0] LP_ONE   = 1;

  state_t           r_state;
  logic             r_write;
  logic [IDX_W-1:0] r_index;
  logic [GRB_W-1:0] r_color;
  logic             r_busy;
  logic             r_done;
  logic             r_clip;
  logic [IDX_W:0]   r_left;   // writes still to issue after the one on the port

  logic [1:0]       w_req;
  logic [1:0]       w_gnt;
  logic             w_accept;
  logic             w_last;
  fill_cmd_t        w_cmd;
  logic [IDX_W:0]   w_start_x;
  logic [IDX_W:0]   w_end;
  logic [IDX_W:0]   w_eff;
  logic             w_clip;

  // Requests are only presented while idle and out of reset, so both
  // readies are forced low during FILL and while rst_n is asserted.
  assign w_req = {fx_valid, host_valid} & {2{(r_state == IDLE) && rst_n}};

  ws2812_rr_arb2 u_arb (
    .clk_g  (clk_g),
    .rst_n  (rst_n),
    .req    (w_req),
    .accept (w_accept),
    .gnt    (w_gnt),
    .last   (w_last)
  );

  assign host_ready = w_gnt[0];
  assign fx_ready   = w_gnt[1];
  assign w_accept   = |w_gnt;

  always_comb begin
    w_cmd = w_gnt[1] ? fill_cmd_t'{start: fx_start,   count: fx_count,   color: fx_color}
                     : fill_cmd_t'{start: host_start, count: host_count, color: host_color};
  end

  // Range clipping in IDX_W+1 bits so start+count cannot overflow.
  assign w_start_x = {1'b0, w_cmd.start};
  assign w_end     = w_start_x + {1'b0, w_cmd.count};

  always_comb begin
    w_eff  = {1'b0, w_cmd.count};
    w_clip = 1'b0;
    if (w_start_x >= LP_SC) begin
      w_eff  = '0;
      w_clip = 1'b1;
    end else if (w_end > LP_SC) begin
      w_eff  = LP_SC - w_start_x;
      w_clip = 1'b1;
    end
  end

  always_ff @(posedge clk_g or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_write <= 1'b0;
      r_index <= '0;
      r_color <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_clip  <= 1'b0;
      r_left  <= '0;
    end else begin
      r_done <= 1'b0;
      r_clip <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_write <= 1'b0;
          if (w_accept) begin
            r_clip <= w_clip;
            if (w_eff == '0) begin
              // Nothing to write: finish immediately, leave the port as is.
              r_done <= 1'b1;
            end else begin
              // First write goes out with the state change; r_left counts
              // the remainder so cmd_done can ride on the final write.
              r_state <= FILL;
              r_busy  <= 1'b1;
              r_write <= 1'b1;
              r_index <= w_cmd.start;
              r_color <= w_cmd.color;
              r_left  <= w_eff - LP_ONE_X;
              r_done  <= (w_eff == LP_ONE_X);
            end
          end
        end
        FILL: begin
          if (r_left != '0) begin
            r_write <= 1'b1;
            r_index <= r_index + LP_ONE;
            r_left  <= r_left - LP_ONE_X;
            r_done  <= (r_left == LP_ONE_X);
          end else begin
            r_write <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign strip_write     = r_write;
  assign strip_index     = r_index;
  assign strip_color_grb = r_color;
  assign busy            = r_busy;
  assign grant_fx        = w_last;
  assign cmd_done        = r_done;
  assign err_clip        = r_clip;

endmodule

// File: tb/tb_ws2812_strip_fill_arbiter.sv
`timescale 1ns/1ps
module tb_ws2812_strip_fill_arbiter;

  logic        clk_g = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_valid = 1'b0, fx_valid = 1'b0;
  logic        host_ready, fx_ready;
  logic [15:0] host_start = '0, host_count = '0, fx_start = '0, fx_count = '0;
  logic [23:0] host_color = '0, fx_color = '0;
  logic        strip_write, busy, grant_fx, cmd_done, err_clip;
  logic [15:0] strip_index;
  logic [23:0] strip_color_grb;

  ws2812_strip_fill_arbiter #(.LED_COUNT(150), .IDX_W(16)) dut (
    .clk_g(clk_g), .rst_n(rst_n),
    .host_valid(host_valid), .host_ready(host_ready), .host_start(host_start),
    .host_count(host_count), .host_color(host_color),
    .fx_valid(fx_valid), .fx_ready(fx_ready), .fx_start(fx_start),
    .fx_count(fx_count), .fx_color(fx_color),
    .strip_write(strip_write), .strip_index(strip_index),
    .strip_color_grb(strip_color_grb), .busy(busy), .grant_fx(grant_fx),
    .cmd_done(cmd_done), .err_clip(err_clip)
  );

  always #5 clk_g = ~clk_g;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  always @(posedge clk_g) cyc <= cyc + 1;

  // event log, sampled on the falling edge
  int          wr_cyc[$];
  logic [15:0] wr_idx[$];
  logic [23:0] wr_col[$];
  int          done_cyc[$];
  int          clip_cyc[$];
  bit          acc_who[$];
  int          busy_n = 0;
  int          both_rdy = 0;

  always @(negedge clk_g) begin
    if (strip_write) begin
      wr_cyc.push_back(cyc);
      wr_idx.push_back(strip_index);
      wr_col.push_back(strip_color_grb);
    end
    if (cmd_done) done_cyc.push_back(cyc);
    if (err_clip) clip_cyc.push_back(cyc);
    if (busy) busy_n++;
    if (host_ready && fx_ready) both_rdy++;
    if (host_valid && host_ready) acc_who.push_back(1'b0);
    if (fx_valid && fx_ready) acc_who.push_back(1'b1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_cyc.delete(); wr_idx.delete(); wr_col.delete();
    done_cyc.delete(); clip_cyc.delete(); acc_who.delete();
    busy_n = 0; both_rdy = 0;
  endtask

  // Present a command, hold valid until accepted; acc = cycle in which the
  // first write (or done pulse) is expected.
  task automatic send(input bit fx, input logic [15:0] s, input logic [15:0] c,
                      input logic [23:0] col, output int acc);
    bit got = 1'b0;
    if (fx) begin fx_valid = 1'b1; fx_start = s; fx_count = c; fx_color = col; end
    else    begin host_valid = 1'b1; host_start = s; host_count = c; host_color = col; end
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk_g);
      if (fx ? fx_ready : host_ready) got = 1'b1;
    end
    if (got) begin
      @(posedge clk_g); #1;
      acc = cyc;
    end else begin
      chk("accept_timeout", 64'd0, 64'd1);
      acc = -1;
    end
    if (fx) fx_valid = 1'b0; else host_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_g);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, acc2, n;

    // reset state
    #13;
    chk("rst_write", strip_write, 0);
    chk("rst_index", strip_index, 0);
    chk("rst_color", strip_color_grb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", cmd_done, 0);
    chk("rst_clip", err_clip, 0);
    chk("rst_grant_fx", grant_fx, 1);
    #4 rst_n = 1'b1;
    idle(2);

    // 1: basic host fill
    clear_log();
    send(1'b0, 16'd0, 16'd3, 24'h0A0000, acc);
    idle(6);
    chk("t1_nwr", wr_cyc.size(), 3);
    if (wr_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t1_idx", wr_idx[i], i);
        chk("t1_col", wr_col[i], 24'h0A0000);
        chk("t1_cyc", wr_cyc[i], acc + i);
      end
    end
    chk("t1_ndone", done_cyc.size(), 1);
    if (done_cyc.size() == 1) chk("t1_done_cyc", done_cyc[0], acc + 2);
    chk("t1_nclip", clip_cyc.size(), 0);
    chk("t1_grant", grant_fx, 0);

    // 3: partial clip on fx
    clear_log();
    send(1'b1, 16'd147, 16'd5, 24'h00FF00, acc);
    idle(6);
    chk("t3_nwr", wr_cyc.size(), 2);
    if (wr_cyc.size() == 2) begin
      chk("t3_idx0", wr_idx[0], 147);
      chk("t3_idx1", wr_idx[1], 148);
      chk("t3_cyc0", wr_cyc[0], acc);
    end
    chk("t3_nclip", clip_cyc.size(), 1);
    if (clip_cyc.size() == 1) chk("t3_clip_cyc", clip_cyc[0], acc);
    chk("t3_ndone", done_cyc.size(), 1);
    if (done_cyc.size() == 1) chk("t3_done_cyc", done_cyc[0], acc + 1);
    chk("t3_grant", grant_fx, 1);

    // 2: contention, round robin
    clear_log();
    fork
      begin
        int a;
        for (int i = 0; i < 3; i++) send(1'b0, 16'd20, 16'd2, 24'h000011, a);
      end
      begin
        int b;
        for (int j = 0; j < 3; j++) send(1'b1, 16'd40, 16'd2, 24'h002200, b);
      end
    join
    idle(6);
    chk("t2_nacc", acc_who.size(), 6);
    if (acc_who.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t2_order", acc_who[i], i % 2);
    end
    chk("t2_both_rdy", both_rdy, 0);
    chk("t2_nwr", wr_cyc.size(), 12);
    if (wr_cyc.size() == 12) begin
      for (int i = 0; i < 6; i++) begin
        chk("t2_pair", wr_cyc[2*i+1] - wr_cyc[2*i], 1);
        chk("t2_idx", wr_idx[2*i], (i % 2) ? 40 : 20);
      end
      for (int i = 0; i < 5; i++) chk("t2_gap", wr_cyc[2*i+2] - wr_cyc[2*i+1], 2);
    end

    // 4: degenerate commands
    clear_log();
    send(1'b0, 16'd5, 16'd0, 24'h123456, acc);
    idle(3);
    send(1'b0, 16'd149, 16'd4, 24'h654321, acc2);
    idle(3);
    chk("t4_nwr", wr_cyc.size(), 0);
    chk("t4_ndone", done_cyc.size(), 2);
    if (done_cyc.size() == 2) begin
      chk("t4_done0", done_cyc[0], acc);
      chk("t4_done1", done_cyc[1], acc2);
    end
    chk("t4_nclip", clip_cyc.size(), 1);
    if (clip_cyc.size() == 1) chk("t4_clip_cyc", clip_cyc[0], acc2);

    // 5: reset in the middle of a fill
    clear_log();
    send(1'b1, 16'd10, 16'd50, 24'hABCDEF, acc);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
        @(negedge clk_g);
        if (wr_cyc.size() >= 20) seen = 1'b1;
      end
      chk("t5_reach20", seen, 1);
    end
    #2 rst_n = 1'b0;
    host_valid = 1'b1;
    #1;
    chk("t5_write", strip_write, 0);
    chk("t5_index", strip_index, 0);
    chk("t5_color", strip_color_grb, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", cmd_done, 0);
    chk("t5_clip", err_clip, 0);
    chk("t5_grant", grant_fx, 1);
    chk("t5_hready", host_ready, 0);
    chk("t5_fready", fx_ready, 0);
    n = wr_cyc.size();
    repeat (3) @(negedge clk_g);
    chk("t5_nomore", wr_cyc.size(), n);
    host_valid = 1'b0;
    @(posedge clk_g); #3 rst_n = 1'b1;
    idle(1);
    clear_log();
    send(1'b0, 16'd0, 16'd1, 24'h0000FF, acc);
    idle(4);
    chk("t5_nwr", wr_cyc.size(), 1);
    if (wr_cyc.size() == 1) chk("t5_idx", wr_idx[0], 0);
    chk("t5_ndone", done_cyc.size(), 1);
    if (done_cyc.size() == 1) chk("t5_done_cyc", done_cyc[0], acc);

    // 6: full span clipped to the strip
    clear_log();
    send(1'b0, 16'd0, 16'hFFFF, 24'h010203, acc);
    idle(160);
    chk("t6_nwr", wr_cyc.size(), 149);
    if (wr_cyc.size() == 149) begin
      n = 0;
      for (int i = 0; i < 149; i++) if (wr_idx[i] !== i || wr_cyc[i] !== acc + i) n++;
      chk("t6_seq_errs", n, 0);
      chk("t6_last_idx", wr_idx[148], 148);
    end
    chk("t6_nclip", clip_cyc.size(), 1);
    if (clip_cyc.size() == 1) chk("t6_clip_cyc", clip_cyc[0], acc);
    chk("t6_ndone", done_cyc.size(), 1);
    if (done_cyc.size() == 1) chk("t6_done_cyc", done_cyc[0], acc + 148);
    chk("t6_busy", busy_n, 149);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
